// File: rtl/config_pkg.sv
// Shared configuration for the AFU register file and its host-side loader.
// Defines the register-file data types (vector_t, ternary_matrix_t), the
// number of vector registers, the loader beat width, the loader select width
// and the loader FSM state enum.
package config_pkg;

  localparam int unsigned NumVectorRegisters = 4;
  localparam int unsigned VectorWidth        = 128;
  localparam int unsigned TernaryDim         = 6;

  typedef logic [VectorWidth-1:0] vector_t;
  typedef logic [1:0] trit_t;
  typedef trit_t [TernaryDim-1:0][TernaryDim-1:0] ternary_matrix_t;

  localparam int unsigned LoaderBeatWidth = 32;
  // Select encodes every vector register plus one extra code for the matrix.
  localparam int unsigned LoaderSelWidth  = $clog2(NumVectorRegisters + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    READ
  } loader_state_e;

endpackage

// File: rtl/reg_loader_if.sv
// Host-facing bus of reg_loader: command handshake, load beat stream,
// readback beat stream and the done/err completion pulses.
//   master : host side (drives cmd_*_i, data_*_i, rd_ready_i)
//   slave  : reg_loader side (drives cmd_ready_o, data_ready_o, rd_*_o,
//            done_o, err_o)
interface reg_loader_if
  import config_pkg::*;
#(
  parameter int unsigned BeatWidth = LoaderBeatWidth
) ();

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [LoaderSelWidth-1:0] cmd_sel_i;
  logic                      cmd_rd_i;

  logic                      data_valid_i;
  logic                      data_ready_o;
  logic [BeatWidth-1:0]      data_i;

  logic                      rd_valid_o;
  logic                      rd_ready_i;
  logic [BeatWidth-1:0]      rd_data_o;
  logic                      rd_last_o;

  logic                      done_o;
  logic                      err_o;

  modport master (
    output cmd_valid_i, cmd_sel_i, cmd_rd_i,
    output data_valid_i, data_i,
    output rd_ready_i,
    input  cmd_ready_o, data_ready_o,
    input  rd_valid_o, rd_data_o, rd_last_o,
    input  done_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_sel_i, cmd_rd_i,
    input  data_valid_i, data_i,
    input  rd_ready_i,
    output cmd_ready_o, data_ready_o,
    output rd_valid_o, rd_data_o, rd_last_o,
    output done_o, err_o
  );

endinterface

// File: rtl/reg_loader.sv
// Host-side load sequencer for the AFU register file.
// A command names one destination (vector register or ternary matrix); the
// destination's contents arrive as BeatWidth-bit beats (beat 0 least
// significant) and are committed with a single one-cycle write enable.
// Optional readback (macro REG_LOADER_READBACK_EN) snapshots a register and
// streams it out in the same beat format; without it, readback commands are
// rejected with err and the rd_* outputs are tied low.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   host                reg_loader_if.slave (cmd / data / rd streams, done, err)
//   w_v_en_o/w_v_data_o vector register write port (one-hot enable)
//   w_tm_en_o/w_tm_data_o ternary matrix write port
//   r_v_data_i/r_tm_data_i register file read data (readback snapshot source)
module reg_loader
  import config_pkg::*;
#(
  parameter int unsigned BeatWidth = LoaderBeatWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  reg_loader_if.slave                   host,
  output logic [NumVectorRegisters-1:0] w_v_en_o,
  output vector_t                       w_v_data_o [NumVectorRegisters],
  output logic                          w_tm_en_o,
  output ternary_matrix_t               w_tm_data_o,
  input  vector_t                       r_v_data_i [NumVectorRegisters],
  input  ternary_matrix_t               r_tm_data_i
);

  localparam int unsigned VectorBits  = $bits(vector_t);
  localparam int unsigned MatrixBits  = $bits(ternary_matrix_t);
  localparam int unsigned VectorBeats = (VectorBits + BeatWidth - 1) / BeatWidth;
  localparam int unsigned MatrixBeats = (MatrixBits + BeatWidth - 1) / BeatWidth;
  localparam int unsigned MaxBeats    = (VectorBeats > MatrixBeats) ? VectorBeats : MatrixBeats;
  localparam int unsigned BufWidth    = MaxBeats * BeatWidth;
  localparam int unsigned CntWidth    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
  localparam int unsigned VIdxWidth   = (NumVectorRegisters > 1) ? $clog2(NumVectorRegisters) : 1;
  localparam logic [LoaderSelWidth-1:0] MatrixSel = LoaderSelWidth'(NumVectorRegisters);
  localparam logic [CntWidth-1:0]       CntOne    = CntWidth'(1);

  loader_state_e                       state_q;
  logic [CntWidth-1:0]                 cnt_q;
  logic [CntWidth-1:0]                 last_q;
  logic [LoaderSelWidth-1:0]           sel_q;
  logic [MaxBeats-1:0][BeatWidth-1:0]  beat_buf_q;
  logic [BufWidth-1:0]                 buf_flat;

  logic                                cmd_ready_q;
  logic                                data_ready_q;
  logic [NumVectorRegisters-1:0]       v_en_q;
  logic                                tm_en_q;
  logic                                done_q;
  logic                                err_q;

  logic                                cmd_fire;
  logic                                cmd_bad;
  logic                                cmd_is_tm;
  logic [CntWidth-1:0]                 cmd_last;

  // cmd_ready_q resets to 1 so the block is ready in the first cycle after
  // reset; masking with rst_i keeps it low while reset is held.
  assign host.cmd_ready_o  = cmd_ready_q & ~rst_i;
  assign host.data_ready_o = data_ready_q;
  assign host.done_o       = done_q;
  assign host.err_o        = err_q;

  assign cmd_fire  = host.cmd_valid_i & host.cmd_ready_o;
  assign cmd_is_tm = (host.cmd_sel_i == MatrixSel);
  assign cmd_last  = cmd_is_tm ? CntWidth'(MatrixBeats - 1) : CntWidth'(VectorBeats - 1);

`ifdef REG_LOADER_READBACK_EN
  logic rd_valid_q;
  logic rd_last_q;

  assign cmd_bad = (host.cmd_sel_i > MatrixSel);

  assign host.rd_valid_o = rd_valid_q;
  assign host.rd_last_o  = rd_last_q;
  assign host.rd_data_o  = beat_buf_q[cnt_q];
`else
  logic unused_rd;

  assign cmd_bad = (host.cmd_sel_i > MatrixSel) | host.cmd_rd_i;

  assign host.rd_valid_o = 1'b0;
  assign host.rd_last_o  = 1'b0;
  assign host.rd_data_o  = '0;

  always_comb begin
    unused_rd = host.rd_ready_i ^ (^r_tm_data_i);
    for (int unsigned i = 0; i < NumVectorRegisters; i++) begin
      unused_rd = unused_rd ^ (^r_v_data_i[i]);
    end
  end
`endif

  // The beat buffer is deliberately left out of reset: a reset mid-load only
  // needs the FSM back in IDLE, the stale contents are never committed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      v_en_q       <= '0;
      tm_en_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef REG_LOADER_READBACK_EN
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
`endif
    end else begin
      v_en_q  <= '0;
      tm_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              sel_q       <= host.cmd_sel_i;
              last_q      <= cmd_last;
              cnt_q       <= '0;
              cmd_ready_q <= 1'b0;
`ifdef REG_LOADER_READBACK_EN
              if (host.cmd_rd_i) begin
                state_q    <= READ;
                rd_valid_q <= 1'b1;
                rd_last_q  <= (cmd_last == '0);
                if (cmd_is_tm) begin
                  beat_buf_q <= BufWidth'(r_tm_data_i);
                end else begin
                  beat_buf_q <= BufWidth'(r_v_data_i[host.cmd_sel_i[VIdxWidth-1:0]]);
                end
              end else
`endif
              begin
                state_q      <= LOAD;
                data_ready_q <= 1'b1;
              end
            end
          end
        end

        LOAD: begin
          if (host.data_valid_i) begin
            beat_buf_q[cnt_q] <= host.data_i;
            if (cnt_q == last_q) begin
              state_q      <= COMMIT;
              data_ready_q <= 1'b0;
              done_q       <= 1'b1;
              if (sel_q == MatrixSel) begin
                tm_en_q <= 1'b1;
              end else begin
                for (int unsigned i = 0; i < NumVectorRegisters; i++) begin
                  v_en_q[i] <= (sel_q == LoaderSelWidth'(i));
                end
              end
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end

        COMMIT: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end

`ifdef REG_LOADER_READBACK_EN
        READ: begin
          if (host.rd_ready_i) begin
            if (cnt_q == last_q) begin
              state_q     <= IDLE;
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + CntOne;
              rd_last_q <= ((cnt_q + CntOne) == last_q);
            end
          end
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_flat    = beat_buf_q;
  assign w_v_en_o    = v_en_q;
  assign w_tm_en_o   = tm_en_q;
  assign w_tm_data_o = buf_flat[MatrixBits-1:0];

  always_comb begin
    for (int unsigned i = 0; i < NumVectorRegisters; i++) begin
      w_v_data_o[i] = buf_flat[VectorBits-1:0];
    end
  end

endmodule

// File: doc/reg_loader.md
# reg_loader

Host-side load sequencer for the AFU register file (vector registers and ternary matrix register). Accepts a command naming one destination, collects that destination's contents as a stream of fixed-width data beats, and then issues a single one-cycle write-enable pulse with the assembled value. It sits between the host/CSR interface and the register file, and is the only writer of the register file during load phases. An optional readback path serialises a register's contents back out in the same beat format.

## Interface
Parameters:
- `BeatWidth`, default 32: bits per data beat.
- `VectorBeats` (localparam) = ceil($bits(vector_t)/BeatWidth).
- `MatrixBeats` (localparam) = ceil($bits(ternary_matrix_t)/BeatWidth).

Ports (clock and reset first):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1, `cmd_ready_o` out 1: command handshake.
- `cmd_sel_i` in $clog2(NumVectorRegisters+1): destination select. 0..NumVectorRegisters-1 = vector register; NumVectorRegisters = ternary matrix.
- `cmd_rd_i` in 1: 1 = readback command, 0 = load command.
- `data_valid_i` in 1, `data_ready_o` out 1, `data_i` in BeatWidth: load beats.
- `w_v_en_o` out NumVectorRegisters, `w_v_data_o` out vector_t[NumVectorRegisters]: vector register write port.
- `w_tm_en_o` out 1, `w_tm_data_o` out ternary_matrix_t: ternary matrix write port.
- `r_v_data_i` in vector_t[NumVectorRegisters], `r_tm_data_i` in ternary_matrix_t: register file read data.
- `rd_valid_o` out 1, `rd_ready_i` in 1, `rd_data_o` out BeatWidth, `rd_last_o` out 1: readback stream.
- `done_o` out 1: one-cycle pulse when a command completes.
- `err_o` out 1: one-cycle pulse when a command is rejected.

## Operation
The block is a four-state FSM: IDLE, LOAD, COMMIT, READ.

- **IDLE**
  - `cmd_ready_o`=1.
  - A command is accepted when `cmd_valid_i && cmd_ready_o`; `cmd_sel_i` and `cmd_rd_i` are latched at acceptance.
  - Invalid commands are consumed without any further effect. A command is invalid if `cmd_sel_i` > NumVectorRegisters, or if it is a readback while the macro is off. On an invalid command: `err_o` pulses the next cycle, the FSM stays in IDLE, and no beats are consumed.
  - A valid load moves to LOAD with the beat counter at 0. Beat count N = VectorBeats or MatrixBeats, according to the destination.
  - A valid readback snapshots the selected register into the beat buffer and moves to READ.
- **LOAD**
  - `data_ready_o`=1. Each accepted beat is written into buffer slot `[cnt*BeatWidth +: BeatWidth]`, so beat 0 is the least significant.
  - In the final beat, bits beyond the destination width are ignored.
  - After beat N-1 is accepted, the FSM moves to COMMIT.
  - Stalls (`data_valid_i`=0) are allowed indefinitely.
- **COMMIT** (exactly one cycle)
  - Asserts either the one-hot `w_v_en_o[sel]` or `w_tm_en_o`, together with `done_o`.
  - `w_v_data_o` drives the buffer on every element. `w_tm_data_o` drives the buffer.
  - Next state is IDLE.
- **READ**
  - `rd_valid_o`=1 and `rd_data_o` = buffer slot `cnt`; `rd_last_o`=1 on slot N-1.
  - The counter advances on `rd_valid_o && rd_ready_i`.
  - After the last beat transfers: `done_o` pulses and the FSM moves to IDLE.
  - The snapshot is unaffected by later register-file writes.
- **Reset**
  - Every output is 0: `cmd_ready_o`, `data_ready_o`, all write enables, `rd_valid_o`, `rd_last_o`, `done_o`, `err_o`.
  - FSM goes to IDLE and the counter goes to 0.
  - The buffer is not reset. Data outputs are don't-care while their enable is low.
  - Reset during LOAD discards the partial buffer. No write enable is ever asserted after a reset until a full load completes.
- **Single writer**: at most one write enable is high in any cycle. The `cmd_ready_o` and `data_ready_o` outputs are never high together.

## Timing
- `cmd_ready_o` is registered and is high in the first cycle after reset deasserts.
- **Load**:
  - Command accepted at cycle t.
  - Beats accepted at t+1 … t+N when there are no stalls.
  - COMMIT enables are high in cycle t+N+1, and the register updates at the end of that cycle.
  - `cmd_ready_o` is high again at t+N+2.
- **Readback**: the first beat is valid in cycle t+1. With `rd_ready_i` held at 1, the last beat is in cycle t+N, and `done_o` is high in cycle t+N+1.
- **Error**: `err_o` is high in cycle t+1, and `cmd_ready_o` stays high throughout.

## Configuration
- Macro `REG_LOADER_READBACK_EN`.
  - **Defined**: the READ state and snapshot path are compiled in.
  - **Undefined**:
    - READ is absent.
    - `rd_valid_o`, `rd_data_o` and `rd_last_o` are tied to 0.
    - `r_v_data_i` and `r_tm_data_i` are unused.
    - Any command with `cmd_rd_i`=1 is rejected with `err_o`.
  - Port list is identical in both builds.

## Structure
- **`config_pkg`** holds:
  - `NumVectorRegisters`, `vector_t`, `ternary_matrix_t` (existing);
  - new: `LoaderBeatWidth`, and the enum `loader_state_e` {IDLE, LOAD, COMMIT, READ}.
- **Beat buffer**: max(VectorBeats, MatrixBeats)*BeatWidth bits, single instance, inline.
- **Sub-modules**: none. The FSM, counter and buffer live in `reg_loader`, which connects directly to `registers`.

## Test plan
Test configuration: NumVectorRegisters=4, 128-bit `vector_t`, BeatWidth=32.

1. Load to register 2 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, no stalls → `w_v_en_o`=4'b0100 for one cycle at t+5 with data 0x44444444_33333333_22222222_11111111; `done_o` at t+5; `cmd_ready_o` at t+6.
2. Same load with `data_valid_i` low for 3 cycles between beats 1 and 2 → identical data; commit delayed by 3 cycles.
3. Command with `cmd_sel_i`=5 → `err_o` pulses at t+1, no enables, `data_ready_o` stays 0, next command accepted at t+1.
4. Matrix load (sel=4, MatrixBeats beats of incrementing values) → only `w_tm_en_o` pulses, with data equal to the concatenated beats truncated to $bits(ternary_matrix_t).
5. `rst_i` asserted after 2 of 4 beats → all outputs 0 next cycle, no write enable; a following full load to register 0 commits correctly.
6. With `REG_LOADER_READBACK_EN`: readback of register 2 after scenario 1, with `rd_ready_i` toggling → beats 0x11111111…0x44444444 in order, `rd_last_o` on the 4th beat, `done_o` after. Without the macro: the same command → `err_o` and `rd_valid_o`=0.
